// File: rtl/mdio_master_pkg.sv
// Shared MDIO frame constants, FSM state type and the
// frame builder used by the clause-22 management master.
package mdio_master_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_GAP,
      S_DONE
   } state_t;

   localparam logic [1:0] ST_CODE = 2'b01;
   localparam logic [1:0] OP_WR   = 2'b01;
   localparam logic [1:0] OP_RD   = 2'b10;
   localparam logic [1:0] TA_WR   = 2'b10;

   localparam int FRAME_BITS = 32;
   localparam int PRE_BITS   = 32;

   localparam logic [4:0] K_REG0 = 5'd13;
   localparam logic [4:0] K_TA1  = 5'd15;
   localparam logic [4:0] K_DATA = 5'd16;

   // Read frames carry ones in TA/DATA: the pad is released there.
   function automatic logic [31:0] build_frame(
      input logic        wr,
      input logic [4:0]  phy,
      input logic [4:0]  rg,
      input logic [15:0] wd
   );
      if (wr)
         return {ST_CODE, OP_WR, phy, rg, TA_WR, wd};
      return {ST_CODE, OP_RD, phy, rg, 2'b11, 16'hFFFF};
   endfunction

endpackage

// File: rtl/mdio_mdc_gen.sv
// MDC divider: free-runs while enabled and emits one-cycle
// strobes on the clk edges that drive MDC low and high.
module mdio_mdc_gen #(
   parameter int MDC_HALF = 20
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic mdc,
   output logic fall_en,
   output logic rise_en
);

   localparam int CW = $clog2(2 * MDC_HALF);
   localparam logic [CW-1:0] CNT_HALF = CW'(MDC_HALF);
   localparam logic [CW-1:0] CNT_LAST = CW'(2 * MDC_HALF - 1);

   logic [CW-1:0] cnt;

   assign fall_en = run && (cnt == '0);
   assign rise_en = run && (cnt == CNT_HALF);

   always_ff @(posedge clk) begin
      if (rst || !run) begin
         cnt <= '0;
         mdc <= 1'b0;
      end else begin
         cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
         if (fall_en)
            mdc <= 1'b0;
         else if (rise_en)
            mdc <= 1'b1;
      end
   end

endmodule

// File: rtl/mdio_master.sv
// Clause-22 MDIO master: one read/write command at a time,
// serialized on MDC/MDIO, read data and TA error returned.
module mdio_master
   import mdio_master_pkg::*;
#(
   parameter int MDC_HALF    = 20,
   parameter bit PREAMBLE_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [4:0]  cmd_phy_addr,
   input  logic [4:0]  cmd_reg_addr,
   input  logic [15:0] cmd_wdata,
   output logic        rsp_valid,
   output logic [15:0] rsp_rdata,
   output logic        rsp_error,
   output logic        busy,
   output logic        mdc,
   output logic        mdio_o,
   output logic        mdio_oe,
   input  logic        mdio_i
);

   if (MDC_HALF < 2) begin : g_bad_half
      $fatal(1, "mdio_master: MDC_HALF must be >= 2");
   end

   localparam int PRE   = PREAMBLE_EN ? PRE_BITS : 0;
   localparam int NBITS = PRE + FRAME_BITS;
   localparam logic [5:0] LAST = 6'(NBITS - 1);

   state_t      state;
   state_t      state_nxt;
   logic [5:0]  bit_cnt;
   logic [31:0] tx;
   logic [15:0] rx;
   logic        wr;
   logic        run;
   logic        fall_en;
   logic        rise_en;
   logic        in_frame;
   logic [4:0]  kbit;

   // With a preamble, frame bits start at count 32.
   assign in_frame = !PREAMBLE_EN || bit_cnt[5];
   assign kbit     = bit_cnt[4:0];
   assign run      = (state == S_SHIFT) || (state == S_GAP);

   mdio_mdc_gen #(
      .MDC_HALF (MDC_HALF)
   ) u_mdc (
      .clk     (clk),
      .rst     (rst),
      .run     (run),
      .mdc     (mdc),
      .fall_en (fall_en),
      .rise_en (rise_en)
   );

   always_ff @(posedge clk) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cmd_ready = (state == S_IDLE);
      busy      = (state != S_IDLE);
      rsp_valid = (state == S_DONE);
      unique case (state)
         S_IDLE:
            if (cmd_valid)
               state_nxt = S_SHIFT;
         S_SHIFT:
            if (rise_en && bit_cnt == LAST)
               state_nxt = S_GAP;
         S_GAP:
            if (fall_en && bit_cnt[0])
               state_nxt = S_DONE;
         S_DONE:
            state_nxt = S_IDLE;
         default:
            state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt   <= '0;
         tx        <= '0;
         rx        <= '0;
         wr        <= 1'b0;
         mdio_o    <= 1'b1;
         mdio_oe   <= 1'b0;
         rsp_rdata <= '0;
         rsp_error <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  wr        <= cmd_write;
                  tx        <= build_frame(cmd_write, cmd_phy_addr,
                                           cmd_reg_addr, cmd_wdata);
                  bit_cnt   <= '0;
                  rsp_rdata <= '0;
                  rsp_error <= 1'b0;
               end
            end
            S_SHIFT: begin
               if (fall_en) begin
                  if (!in_frame) begin
                     mdio_o  <= 1'b1;
                     mdio_oe <= 1'b1;
                  end else begin
                     mdio_o  <= tx[31];
                     tx      <= {tx[30:0], 1'b1};
                     mdio_oe <= wr || (kbit <= K_REG0);
                  end
               end
               if (rise_en) begin
                  if (!wr && in_frame && kbit == K_TA1)
                     rsp_error <= mdio_i;
                  if (!wr && in_frame && kbit >= K_DATA)
                     rx <= {rx[14:0], mdio_i};
                  bit_cnt <= (bit_cnt == LAST) ? '0 : bit_cnt + 6'd1;
               end
            end
            S_GAP: begin
               // First fall releases the line, second one ends the gap.
               if (fall_en) begin
                  if (!bit_cnt[0]) begin
                     mdio_o  <= 1'b1;
                     mdio_oe <= 1'b0;
                     bit_cnt <= 6'd1;
                  end else begin
                     rsp_rdata <= wr ? 16'h0000 : rx;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mdio_master.sv
// Directed self-checking bench for mdio_master (MDC_HALF=4),
// with and without preamble.
module tb_mdio_master;

   localparam int H = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        cmd_valid = 1'b0;
   logic        cmd_valid0 = 1'b0;
   logic        cmd_write = 1'b0;
   logic [4:0]  phy = '0;
   logic [4:0]  rg = '0;
   logic [15:0] wd = '0;
   logic        mdio_i = 1'b1;

   logic        ready, rv, err, busy, mdc, mo, moe;
   logic [15:0] rdata;
   logic        ready0, rv0, err0, busy0, mdc0, mo0, moe0;
   logic [15:0] rdata0;

   logic sel = 1'b0;
   logic ready_s, rv_s, mdc_s, mo_s, moe_s, err_s;
   logic [15:0] rdata_s;

   assign ready_s = sel ? ready0 : ready;
   assign rv_s    = sel ? rv0 : rv;
   assign mdc_s   = sel ? mdc0 : mdc;
   assign mo_s    = sel ? mo0 : mo;
   assign moe_s   = sel ? moe0 : moe;
   assign err_s   = sel ? err0 : err;
   assign rdata_s = sel ? rdata0 : rdata;

   int passed = 0;
   int total = 0;

   mdio_master #(.MDC_HALF(H), .PREAMBLE_EN(1'b1)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(ready),
      .cmd_write(cmd_write), .cmd_phy_addr(phy),
      .cmd_reg_addr(rg), .cmd_wdata(wd),
      .rsp_valid(rv), .rsp_rdata(rdata), .rsp_error(err),
      .busy(busy), .mdc(mdc), .mdio_o(mo), .mdio_oe(moe),
      .mdio_i(mdio_i)
   );

   mdio_master #(.MDC_HALF(H), .PREAMBLE_EN(1'b0)) dut0 (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid0), .cmd_ready(ready0),
      .cmd_write(cmd_write), .cmd_phy_addr(phy),
      .cmd_reg_addr(rg), .cmd_wdata(wd),
      .rsp_valid(rv0), .rsp_rdata(rdata0), .rsp_error(err0),
      .busy(busy0), .mdc(mdc0), .mdio_o(mo0), .mdio_oe(moe0),
      .mdio_i(mdio_i)
   );

   initial begin
      #2ms;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   // Issues one command, plays the PHY, records the bit stream.
   task automatic do_frame(
      input  logic        use0,
      input  logic        w,
      input  logic [4:0]  pa,
      input  logic [4:0]  ra,
      input  logic [15:0] wdat,
      input  logic [15:0] pdata,
      input  logic        present,
      output logic [63:0] so,
      output logic [63:0] soe,
      output int          lat,
      output int          nrise
   );
      int nb, pre, k, ph, j;
      logic prev;
      nb = use0 ? 32 : 64;
      pre = nb - 32;
      so = '0;
      soe = '0;
      lat = -1;
      nrise = 0;
      sel = use0;
      @(negedge clk);
      cmd_write = w; phy = pa; rg = ra; wd = wdat;
      if (use0) cmd_valid0 = 1'b1;
      else cmd_valid = 1'b1;
      for (int t = 0; t < 2000 && !ready_s; t++) @(negedge clk);
      @(posedge clk); #1;
      cmd_valid = 1'b0; cmd_valid0 = 1'b0;
      cmd_write = ~w; phy = ~pa; rg = ~ra; wd = ~wdat;
      prev = 1'b0;
      for (int c = 1; c <= 2 * (nb + 1) * 2 * H + 20; c++) begin
         @(posedge clk); #1;
         k = (c - 1) / (2 * H);
         ph = (c - 1) % (2 * H);
         if (mdc_s && !prev) nrise++;
         prev = mdc_s;
         if (k < nb && ph == 0) begin
            so[nb-1-k] = mo_s;
            soe[nb-1-k] = moe_s;
            j = k - pre;
            mdio_i = 1'b1;
            if (present && j == 15) mdio_i = 1'b0;
            if (present && j >= 16) mdio_i = pdata[31-j];
         end
         if (k >= nb) mdio_i = 1'b1;
         if (rv_s) begin
            lat = c;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if ({mdc, mo, moe, rv, busy, ready} !== 6'b010001)
         $display("FAIL reset_ctl: got %b expected 010001",
                  {mdc, mo, moe, rv, busy, ready});
      else passed++;
      total++;
      if ({rdata, err} !== 17'h0)
         $display("FAIL reset_rsp: got %h expected 0", {rdata, err});
      else passed++;
      total++;
      if ({mdc0, mo0, moe0, rv0, busy0, ready0} !== 6'b010001)
         $display("FAIL reset_ctl0: got %b expected 010001",
                  {mdc0, mo0, moe0, rv0, busy0, ready0});
      else passed++;
      rst = 1'b0;
   endtask

   task automatic test_write;
      logic [63:0] so, soe;
      int lat, nr;
      do_frame(1'b0, 1'b1, 5'h01, 5'h00, 16'h3100, 16'h0, 1'b0,
               so, soe, lat, nr);
      total++;
      if (so !== 64'hFFFF_FFFF_5082_3100)
         $display("FAIL wr_stream: got %h expected FFFFFFFF50823100", so);
      else passed++;
      total++;
      if (soe !== 64'hFFFF_FFFF_FFFF_FFFF)
         $display("FAIL wr_oe: got %h expected all ones", soe);
      else passed++;
      total++;
      if (lat !== 521)
         $display("FAIL wr_latency: got %0d expected 521", lat);
      else passed++;
      total++;
      if ({rdata, err} !== 17'h0)
         $display("FAIL wr_rsp: got %h expected 0", {rdata, err});
      else passed++;
      total++;
      if (nr !== 65)
         $display("FAIL wr_mdc_rises: got %0d expected 65", nr);
      else passed++;
      @(posedge clk); #1;
      total++;
      if ({rv, ready, mdc, moe} !== 4'b0100)
         $display("FAIL wr_after: got %b expected 0100",
                  {rv, ready, mdc, moe});
      else passed++;
   endtask

   task automatic test_read;
      logic [63:0] so, soe;
      int lat, nr;
      do_frame(1'b0, 1'b0, 5'h01, 5'h02, 16'hDEAD, 16'h0022, 1'b1,
               so, soe, lat, nr);
      total++;
      if (so[63:18] !== {32'hFFFF_FFFF, 14'b01100000100010})
         $display("FAIL rd_stream: got %h expected FFFFFFFF,1822",
                  so[63:18]);
      else passed++;
      total++;
      if (soe !== 64'hFFFF_FFFF_FFFC_0000)
         $display("FAIL rd_oe: got %h expected FFFFFFFFFFFC0000", soe);
      else passed++;
      total++;
      if (rdata !== 16'h0022 || err !== 1'b0)
         $display("FAIL rd_rsp: got %h/%b expected 0022/0", rdata, err);
      else passed++;
      total++;
      if (lat !== 521)
         $display("FAIL rd_latency: got %0d expected 521", lat);
      else passed++;
   endtask

   task automatic test_no_phy;
      logic [63:0] so, soe;
      int lat, nr;
      do_frame(1'b0, 1'b0, 5'h07, 5'h01, 16'h0, 16'h0, 1'b0,
               so, soe, lat, nr);
      total++;
      if (rdata !== 16'hFFFF || err !== 1'b1)
         $display("FAIL nophy_rsp: got %h/%b expected FFFF/1", rdata, err);
      else passed++;
      total++;
      if (soe !== 64'hFFFF_FFFF_FFFC_0000)
         $display("FAIL nophy_oe: got %h expected FFFFFFFFFFFC0000", soe);
      else passed++;
   endtask

   task automatic test_no_preamble;
      logic [63:0] so, soe;
      int lat, nr;
      do_frame(1'b1, 1'b1, 5'h03, 5'h1F, 16'hA5C3, 16'h0, 1'b0,
               so, soe, lat, nr);
      total++;
      if (so[31:0] !== 32'h51FE_A5C3)
         $display("FAIL np_stream: got %h expected 51FEA5C3", so[31:0]);
      else passed++;
      total++;
      if (soe[31:0] !== 32'hFFFF_FFFF)
         $display("FAIL np_oe: got %h expected FFFFFFFF", soe[31:0]);
      else passed++;
      total++;
      if (lat !== 265)
         $display("FAIL np_latency: got %0d expected 265", lat);
      else passed++;
      total++;
      if (nr !== 33)
         $display("FAIL np_mdc_rises: got %0d expected 33", nr);
      else passed++;
      sel = 1'b0;
   endtask

   task automatic test_back_to_back;
      logic [63:0] sa, sb;
      int c1, c2, bad, k, cb;
      logic rdy522;
      sel = 1'b0;
      sa = '0; sb = '0; c1 = -1; c2 = -1; bad = 0; rdy522 = 1'b0;
      @(negedge clk);
      cmd_write = 1'b1; phy = 5'h02; rg = 5'h04; wd = 16'h1234;
      cmd_valid = 1'b1;
      for (int t = 0; t < 2000 && !ready; t++) @(negedge clk);
      @(posedge clk); #1;
      phy = 5'h1F; rg = 5'h11; wd = 16'hBEEF;
      for (int c = 1; c <= 1100; c++) begin
         @(posedge clk); #1;
         if (c <= 520 && ready) bad++;
         if (c == 522) rdy522 = ready;
         if (c == 523) cmd_valid = 1'b0;
         if (c <= 512 && (c - 1) % (2 * H) == 0) begin
            k = (c - 1) / (2 * H);
            sa[63-k] = mo;
         end
         cb = c - 523;
         if (cb >= 1 && cb <= 512 && (cb - 1) % (2 * H) == 0) begin
            k = (cb - 1) / (2 * H);
            sb[63-k] = mo;
         end
         if (rv && c1 < 0) c1 = c;
         else if (rv && c2 < 0) begin
            c2 = c;
            break;
         end
      end
      cmd_valid = 1'b0;
      total++;
      if (bad !== 0)
         $display("FAIL b2b_ready_low: got %0d ready cycles expected 0", bad);
      else passed++;
      total++;
      if (c1 !== 521 || rdy522 !== 1'b1)
         $display("FAIL b2b_first: got %0d/%b expected 521/1", c1, rdy522);
      else passed++;
      total++;
      if (c2 !== 1044)
         $display("FAIL b2b_second: got %0d expected 1044", c2);
      else passed++;
      total++;
      if (sa !== 64'hFFFF_FFFF_5112_1234)
         $display("FAIL b2b_stream_a: got %h expected FFFFFFFF51121234", sa);
      else passed++;
      total++;
      if (sb !== 64'hFFFF_FFFF_5FC6_BEEF)
         $display("FAIL b2b_stream_b: got %h expected FFFFFFFF5FC6BEEF", sb);
      else passed++;
   endtask

   task automatic test_reset_mid_read;
      logic [63:0] so, soe;
      int lat, nr, nv;
      sel = 1'b0;
      nv = 0;
      @(negedge clk);
      cmd_write = 1'b0; phy = 5'h01; rg = 5'h02;
      cmd_valid = 1'b1;
      for (int t = 0; t < 2000 && !ready; t++) @(negedge clk);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      for (int c = 1; c <= 1 + 2 * H * 52 + 2; c++) begin
         @(posedge clk); #1;
         if (rv) nv++;
      end
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      total++;
      if ({mdc, moe, ready, busy, mo} !== 5'b00101)
         $display("FAIL rst_mid: got %b expected 00101",
                  {mdc, moe, ready, busy, mo});
      else passed++;
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 600; c++) begin
         @(posedge clk); #1;
         if (rv) nv++;
      end
      total++;
      if (nv !== 0)
         $display("FAIL rst_no_rsp: got %0d pulses expected 0", nv);
      else passed++;
      do_frame(1'b0, 1'b1, 5'h1F, 5'h11, 16'hBEEF, 16'h0, 1'b0,
               so, soe, lat, nr);
      total++;
      if (so !== 64'hFFFF_FFFF_5FC6_BEEF || lat !== 521)
         $display("FAIL rst_next_cmd: got %h/%0d expected FFFFFFFF5FC6BEEF/521",
                  so, lat);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_no_phy();
      test_no_preamble();
      test_back_to_back();
      test_reset_mid_read();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
